// File: rtl/led_frame_buffer.sv
// Double-buffered RGB frame store feeding the LED strand driver.
// Define LED_FB_BRIGHTNESS_EN for a third, brightness-scaling read stage.
module led_frame_buffer #(
  parameter int NUM_LEDS = 2,
  parameter int COLOR_WIDTH = 8,
  localparam int CounterWidth = $clog2(NUM_LEDS)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    wr_valid_in,
  output logic                    wr_ready_out,
  input  logic [CounterWidth-1:0] wr_addr_in,
  input  logic [COLOR_WIDTH-1:0]  wr_red_in,
  input  logic [COLOR_WIDTH-1:0]  wr_green_in,
  input  logic [COLOR_WIDTH-1:0]  wr_blue_in,
  input  logic                    wr_frame_done_in,
  input  logic [CounterWidth-1:0] next_led_request,
  output logic [COLOR_WIDTH-1:0]  red_out,
  output logic [COLOR_WIDTH-1:0]  green_out,
  output logic [COLOR_WIDTH-1:0]  blue_out,
  output logic                    color_valid,
  output logic                    swap_pending_out,
  output logic                    front_sel_out
`ifdef LED_FB_BRIGHTNESS_EN
  ,
  input  logic [7:0]              brightness_in
`endif
);

  localparam int PW = 3 * COLOR_WIDTH;
  localparam logic [CounterWidth-1:0] LastIdx =
    CounterWidth'(NUM_LEDS - 1);
  localparam logic [CounterWidth:0] AddrLim =
    (CounterWidth + 1)'(NUM_LEDS);

  typedef enum logic {IDLE, PENDING} state_e;

  state_e state_q, state_d;
  logic front_sel_q, front_sel_d;
  logic front_loaded_q, front_loaded_d;

  logic [PW-1:0] mem0 [NUM_LEDS];
  logic [PW-1:0] mem1 [NUM_LEDS];

  logic [CounterWidth-1:0] req1_q, req2_q;
  logic v1_q, v2_q;
  logic [PW-1:0] col2_q;
  logic [PW-1:0] rd_data;
  logic boundary, wr_en, rd_ok, valid2;

  assign boundary = (next_led_request == '0) && (req1_q == LastIdx);
  assign wr_en = wr_valid_in && (state_q == IDLE) &&
                 ({1'b0, wr_addr_in} < AddrLim);
  assign rd_ok = {1'b0, req1_q} < AddrLim;

  always_comb begin
    state_d = state_q;
    front_sel_d = front_sel_q;
    front_loaded_d = front_loaded_q;
    unique case (state_q)
      IDLE: begin
        if (wr_frame_done_in) state_d = PENDING;
      end
      PENDING: begin
        if (boundary) begin
          state_d = IDLE;
          front_sel_d = !front_sel_q;
          front_loaded_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      front_sel_q <= 1'b0;
      front_loaded_q <= 1'b0;
    end else begin
      state_q <= state_d;
      front_sel_q <= front_sel_d;
      front_loaded_q <= front_loaded_d;
    end
  end

  // The back buffer is whichever one is not on display.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      if (front_sel_q)
        mem0[wr_addr_in] <= {wr_red_in, wr_green_in, wr_blue_in};
      else
        mem1[wr_addr_in] <= {wr_red_in, wr_green_in, wr_blue_in};
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_ok) rd_data = front_sel_q ? mem1[req1_q] : mem0[req1_q];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      req1_q <= '0;
      req2_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      col2_q <= '0;
    end else begin
      req1_q <= next_led_request;
      req2_q <= req1_q;
      v1_q <= 1'b1;
      v2_q <= v1_q;
      col2_q <= front_loaded_q ? rd_data : '0;
    end
  end

  assign valid2 = v1_q && v2_q && (req1_q == req2_q);

`ifdef LED_FB_BRIGHTNESS_EN
  function automatic logic [COLOR_WIDTH-1:0] scale(
    input logic [COLOR_WIDTH-1:0] c,
    input logic [7:0] b
  );
    logic [COLOR_WIDTH+8:0] p;
    p = (COLOR_WIDTH + 9)'(c) * (COLOR_WIDTH + 9)'({1'b0, b} + 9'd1);
    return p[COLOR_WIDTH+7:8];
  endfunction

  logic [PW-1:0] col3_q;
  logic v3_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      col3_q <= '0;
      v3_q <= 1'b0;
    end else begin
      col3_q <= {scale(col2_q[PW-1 -: COLOR_WIDTH], brightness_in),
                 scale(col2_q[2*COLOR_WIDTH-1 -: COLOR_WIDTH], brightness_in),
                 scale(col2_q[COLOR_WIDTH-1:0], brightness_in)};
      v3_q <= valid2;
    end
  end

  assign {red_out, green_out, blue_out} = col3_q;
  assign color_valid = v3_q;
`else
  assign {red_out, green_out, blue_out} = col2_q;
  assign color_valid = valid2;
`endif

  assign wr_ready_out = (state_q == IDLE);
  assign swap_pending_out = (state_q == PENDING);
  assign front_sel_out = front_sel_q;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Randomized bench for led_frame_buffer against a cycle-history model.
// Honors LED_FB_BRIGHTNESS_EN for the brightness port and latency.
module tb_led_frame_buffer;
  localparam int N = 5;
  localparam int CW = 8;
  localparam int AW = $clog2(N);
`ifdef LED_FB_BRIGHTNESS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wv = 1'b0;
  logic ready_o;
  logic [AW-1:0] wa = '0;
  logic [CW-1:0] wr = '0, wg = '0, wb = '0;
  logic done = 1'b0;
  logic [AW-1:0] req = '0;
  logic [CW-1:0] r_o, g_o, b_o;
  logic valid_o, pend_o, front_o;
  logic [7:0] bri = 8'd255;

  always #5 clk = ~clk;

  led_frame_buffer #(.NUM_LEDS(N), .COLOR_WIDTH(CW)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .wr_valid_in(wv),
    .wr_ready_out(ready_o),
    .wr_addr_in(wa),
    .wr_red_in(wr),
    .wr_green_in(wg),
    .wr_blue_in(wb),
    .wr_frame_done_in(done),
    .next_led_request(req),
    .red_out(r_o),
    .green_out(g_o),
    .blue_out(b_o),
    .color_valid(valid_o),
    .swap_pending_out(pend_o),
    .front_sel_out(front_o)
`ifdef LED_FB_BRIGHTNESS_EN
    ,
    .brightness_in(bri)
`endif
  );

  int total = 0;
  int bad = 0;

  logic [23:0] mem [2][N];
  bit known [2][N];
  bit m_pend, m_front, m_load;
  int cyc;
  int hreq [8];
  logic [23:0] hcol [8];
  bit hkn [8];
  int hbri [8];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int req_at(input int k);
    return (k < 0) ? 0 : hreq[k & 7];
  endfunction

  function automatic logic [23:0] bscale(input logic [23:0] c, input int b);
    logic [23:0] o;
    for (int i = 0; i < 3; i++)
      o[i*8 +: 8] = 8'((int'(c[i*8 +: 8]) * (b + 1)) / 256);
    return o;
  endfunction

  // Spec-level state update for the inputs present at this edge.
  task automatic model_edge();
    int pr;
    int fi;
    int bi;
    pr = req_at(cyc - 1);
    fi = m_front ? 1 : 0;
    bi = m_front ? 0 : 1;
    hcol[cyc & 7] = m_load ? mem[fi][pr] : 24'd0;
    hkn[cyc & 7] = !m_load || known[fi][pr];
    hbri[cyc & 7] = int'(bri);
    if (!m_pend && wv && int'(wa) < N) begin
      mem[bi][wa] = {wr, wg, wb};
      known[bi][wa] = 1'b1;
    end
    if (!m_pend) begin
      if (done) m_pend = 1'b1;
    end else if (int'(req) == 0 && pr == N - 1) begin
      m_pend = 1'b0;
      m_front = !m_front;
      m_load = 1'b1;
    end
    hreq[cyc & 7] = int'(req);
    cyc++;
  endtask

  task automatic check_outs();
    int t;
    int k;
    logic [23:0] ec;
    bit ev;
    t = cyc;
    chk("pending", 32'(pend_o), 32'(m_pend));
    chk("front", 32'(front_o), 32'(m_front));
    chk("ready", 32'(ready_o), 32'(!m_pend));
    ev = (t >= LAT) && (req_at(t - LAT + 1) == req_at(t - LAT));
    chk("valid", 32'(valid_o), 32'(ev));
    if (t < LAT) begin
      chk("color_fill", 32'({r_o, g_o, b_o}), 32'd0);
    end else begin
      k = (t - LAT + 1) & 7;
      if (hkn[k]) begin
        ec = (LAT == 3) ? bscale(hcol[k], hbri[(t - 1) & 7]) : hcol[k];
        chk("color", 32'({r_o, g_o, b_o}), 32'(ec));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic apply_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_color", 32'({r_o, g_o, b_o}), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_front", 32'(front_o), 32'd0);
    chk("rst_pend", 32'(pend_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    m_pend = 1'b0;
    m_front = 1'b0;
    m_load = 1'b0;
    cyc = 0;
    for (int i = 0; i < 8; i++) hreq[i] = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic hold_req(input int r);
    req = AW'(r);
    for (int k = 0; k < LAT; k++) step();
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) known[b][i] = 1'b0;
    apply_reset();

    for (int i = 0; i < N; i++) begin
      wv = 1'b1;
      wa = AW'(i);
      {wr, wg, wb} = {8'(i), 8'(2 * i), 8'(3 * i)};
      step();
    end
    wa = 3'd5;
    {wr, wg, wb} = 24'hFFFFFF;
    step();
    wa = 3'd7;
    step();
    wv = 1'b0;
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    wv = 1'b1;
    wa = 3'd1;
    step();
    wv = 1'b0;
    hold_req(3);
    chk("pre_swap_zero", 32'({r_o, g_o, b_o}), 32'd0);
    for (int r = 0; r < N; r++) begin
      req = AW'(r);
      step();
    end
    req = '0;
    step();
    hold_req(2);
    chk("led2", 32'({r_o, g_o, b_o}), 32'h020406);
    chk("led2_valid", 32'(valid_o), 32'd1);
    chk("one_toggle", 32'(front_o), 32'd1);
    hold_req(1);
    chk("led1_kept", 32'({r_o, g_o, b_o}), 32'h010203);
    for (int k = 0; k < 6; k++) begin
      req = AW'(k % N);
      step();
      chk("churn_valid", 32'(valid_o), 32'd0);
    end

    for (int i = 0; i < 1500; i++) begin
      int m;
      wv = 1'($urandom_range(0, 1));
      wa = AW'($urandom_range(0, 7));
      {wr, wg, wb} = 24'($urandom);
      done = ($urandom_range(0, 29) == 0);
      bri = 8'($urandom);
      m = $urandom_range(0, 9);
      if (m < 5) req = AW'((int'(req) + 1) % N);
      else if (m == 9) req = AW'($urandom_range(0, N - 1));
      if (i == 800) apply_reset();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
